// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues word-aligned fetch requests and buffers in-order
// responses in a small FIFO presented to decode. A redirect flushes buffered and in-flight work.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthLim = (CntW + 1)'(FIFO_DEPTH);

  logic [31:0]     pc_q, pc_d;
  logic [31:0]     next_rsp_pc_q, next_rsp_pc_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] drop_cnt_q, drop_cnt_d;

  logic [31:0] fifo_data_q [FIFO_DEPTH];
  logic [31:0] fifo_pc_q   [FIFO_DEPTH];

  logic        pop;
  logic        push;
  logic        req_fire;
  logic        drop_active;
  logic [CntW:0] credit_sum;
  logic [31:0] redirect_pc_aligned;

  assign redirect_pc_aligned = redirect_pc & 32'hFFFF_FFFC;

  // Handshake and credit decode; requests are gated while reset is asserted.
  always_comb begin
    inst_valid    = (count_q != '0) & ~redirect_valid;
    pop           = inst_valid & inst_ready;
    credit_sum    = {1'b0, outstanding_q} + {1'b0, count_q} - {{CntW{1'b0}}, pop};
    mem_req_valid = rst & ~redirect_valid & (credit_sum < DepthLim);
    mem_req_addr  = pc_q;
    req_fire      = mem_req_valid & mem_req_ready;
    drop_active   = mem_rsp_valid & (drop_cnt_q != '0);
    push          = mem_rsp_valid & (drop_cnt_q == '0) & ~redirect_valid;
    inst_data     = fifo_data_q[rd_ptr_q];
    inst_pc       = fifo_pc_q[rd_ptr_q];
  end

  // Next-state for PC, pointers and counters; a redirect overrides normal operation.
  always_comb begin
    pc_d          = pc_q;
    next_rsp_pc_d = next_rsp_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    if (redirect_valid) begin
      pc_d          = redirect_pc_aligned;
      next_rsp_pc_d = redirect_pc_aligned;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      // Everything still in flight belongs to the old stream, including any response now.
      outstanding_d = outstanding_q - CntW'(mem_rsp_valid);
      drop_cnt_d    = outstanding_q - CntW'(mem_rsp_valid);
    end else begin
      if (req_fire) begin
        pc_d = pc_q + 32'd4;
      end
      outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(mem_rsp_valid);
      if (drop_active) begin
        drop_cnt_d = drop_cnt_q - CntW'(1);
      end
      if (push) begin
        wr_ptr_d      = wr_ptr_q + PtrW'(1);
        next_rsp_pc_d = next_rsp_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      next_rsp_pc_q <= RESET_PC;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      pc_q          <= pc_d;
      next_rsp_pc_q <= next_rsp_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  // FIFO storage; cleared on reset so the head reads zero while empty after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
      end
    end else if (push) begin
      fifo_data_q[wr_ptr_q] <= mem_rsp_data;
      fifo_pc_q[wr_ptr_q]   <= next_rsp_pc_q;
    end
  end

endmodule
